// File: rtl/zad_pkg.sv
// Shared widths and state encoding for the multiplier / accumulator datapath.
package zad_pkg;

    localparam int PROD_W = 24;
    localparam int OP_W   = 12;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/zad_acc_stage.sv
// Accumulates up to LEN unsigned product beats into a wide sum and presents
// each finished frame sum, beat count and carry-out flag on a valid/ready port.
module zad_acc_stage
    import zad_pkg::*;
#(
    parameter int IN_W  = PROD_W,
    parameter int ACC_W = 32,
    parameter int LEN   = 8,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic [CNT_W-1:0] cnt_n;
    logic             close;

    always_comb begin
        sum         = {1'b0, acc_q} + (ACC_W + 1)'(in_data);
        carry       = sum[ACC_W];
        cnt_n       = cnt_q + 1'b1;
        close       = (cnt_n == CNT_W'(LEN)) || in_last;

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (close) begin
                        // Closing beat: publish the frame and start the next from zero.
                        out_data_d  = sum[ACC_W-1:0];
                        out_count_d = cnt_n;
                        out_ovf_d   = ovf_q | carry;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                        cnt_d = cnt_n;
                        ovf_d = ovf_q | carry;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Ready is a pure state decode so it never combinationally follows the handshakes.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_zad_acc_stage.sv
// Drives two LEN=4 stages (32-bit and 25-bit accumulators) with shared stimulus
// and checks them against a frame-level reference model plus literal checkpoints.
module tb_zad_acc_stage;

    localparam int IN_W  = 24;
    localparam int LEN   = 4;
    localparam int CNT_W = 3;
    localparam int AW_A  = 32;
    localparam int AW_B  = 25;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            in_last = 1'b0;
    logic            out_ready = 1'b0;

    logic            a_in_ready, a_out_valid, a_out_ovf;
    logic [AW_A-1:0] a_out_data;
    logic [CNT_W-1:0] a_out_count;
    logic            b_in_ready, b_out_valid, b_out_ovf;
    logic [AW_B-1:0] b_out_data;
    logic [CNT_W-1:0] b_out_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    zad_acc_stage #(.IN_W(IN_W), .ACC_W(AW_A), .LEN(LEN)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .out_count(a_out_count),
        .out_ovf(a_out_ovf)
    );

    zad_acc_stage #(.IN_W(IN_W), .ACC_W(AW_B), .LEN(LEN)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .out_count(b_out_count),
        .out_ovf(b_out_ovf)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true (unwrapped) frame sum; wrapped value and overflow follow from it.
    bit              m_hold = 1'b0;
    longint unsigned m_sum  = 0;
    int              m_cnt  = 0;
    longint unsigned m_osum = 0;
    int              m_ocnt = 0;

    always @(posedge clk) begin
        automatic longint unsigned s = m_sum + longint'(in_data);
        automatic int c = m_cnt + 1;
        if (!rst_n) begin
            m_hold <= 1'b0; m_sum <= 0; m_cnt <= 0; m_osum <= 0; m_ocnt <= 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                if (c == LEN || in_last) begin
                    m_osum <= s; m_ocnt <= c; m_hold <= 1'b1; m_sum <= 0; m_cnt <= 0;
                end else begin
                    m_sum <= s; m_cnt <= c;
                end
            end
        end else if (out_ready) begin
            m_hold <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_in_ready",  a_in_ready,  !m_hold);
            chk("a_out_valid", a_out_valid, m_hold);
            chk("a_out_data",  a_out_data,  m_osum & 64'hFFFF_FFFF);
            chk("a_out_count", a_out_count, m_ocnt);
            chk("a_out_ovf",   a_out_ovf,   (m_osum >> AW_A) != 0);
            chk("b_in_ready",  b_in_ready,  !m_hold);
            chk("b_out_valid", b_out_valid, m_hold);
            chk("b_out_data",  b_out_data,  m_osum & ((64'd1 << AW_B) - 1));
            chk("b_out_count", b_out_count, m_ocnt);
            chk("b_out_ovf",   b_out_ovf,   (m_osum >> AW_B) != 0);
        end
    end

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input bit v, input logic [IN_W-1:0] d, input bit last, input bit rdy);
        in_valid = v; in_data = d; in_last = last; out_ready = rdy;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_en = 1'b1;
        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_out_data", a_out_data, 0);
        chk("reset_in_ready", a_in_ready, 1);
        rst_n = 1'b1;

        // Four max products: no wrap at 32 bits, wrap at 25 bits.
        for (int i = 0; i < 4; i++) cyc(1, 24'hFFE001, 0, 1);
        chk("max_a_valid", a_out_valid, 1);
        chk("max_a_data", a_out_data, 32'h03FF8004);
        chk("max_a_count", a_out_count, 4);
        chk("max_a_ovf", a_out_ovf, 0);
        chk("max_b_data", b_out_data, 25'h1FF8004);
        chk("max_b_ovf", b_out_ovf, 1);
        chk("max_in_ready_low", a_in_ready, 0);
        cyc(1, 24'h000055, 0, 1);
        chk("max_dead_cycle_ready", a_in_ready, 1);
        chk("max_dead_cycle_valid", a_out_valid, 0);
        chk("max_retain_data", a_out_data, 32'h03FF8004);

        // Sticky overflow cleared for the following frame.
        for (int i = 0; i < 4; i++) cyc(1, 24'd1, 0, 1);
        chk("ones_b_data", b_out_data, 4);
        chk("ones_b_ovf", b_out_ovf, 0);
        cyc(0, 0, 0, 1);

        // Early close.
        cyc(1, 24'd10, 0, 1);
        cyc(1, 24'd20, 1, 1);
        chk("early_data", a_out_data, 30);
        chk("early_count", a_out_count, 2);
        cyc(0, 0, 0, 1);
        cyc(1, 24'd5, 1, 1);
        chk("early_next_data", a_out_data, 5);
        chk("early_next_count", a_out_count, 1);
        cyc(0, 0, 0, 1);

        // Backpressure with beats offered while holding.
        for (int i = 0; i < 4; i++) cyc(1, 24'd3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", a_out_valid, 1);
            chk("bp_data", a_out_data, 12);
            chk("bp_in_ready", a_in_ready, 0);
            cyc(1, 24'd99, 0, 0);
        end
        cyc(0, 0, 0, 1);
        chk("bp_release_valid", a_out_valid, 0);
        chk("bp_release_ready", a_in_ready, 1);

        // Bubbles between beats.
        for (int i = 1; i <= 4; i++) begin
            cyc(1, IN_W'(i), 0, 1);
            if (i < 4) begin cyc(0, 24'd77, 0, 1); cyc(0, 24'd77, 0, 1); end
        end
        chk("bubble_data", a_out_data, 10);
        chk("bubble_count", a_out_count, 4);
        cyc(0, 0, 0, 1);

        // in_last on the LEN-th beat closes exactly once.
        for (int i = 0; i < 4; i++) cyc(1, 24'd2, i == 3, 1);
        chk("last_len_count", a_out_count, 4);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("last_len_single", a_out_valid, 0);

        // Reset mid-frame.
        cyc(1, 24'd7, 0, 1);
        cyc(1, 24'd7, 0, 1);
        rst_n = 1'b0;
        cyc(0, 0, 0, 1);
        rst_n = 1'b1;
        chk("rst_mid_data", a_out_data, 0);
        chk("rst_mid_count", a_out_count, 0);
        chk("rst_mid_ovf", a_out_ovf, 0);
        for (int i = 0; i < 4; i++) cyc(1, 24'd1, 0, 1);
        chk("rst_mid_after_data", a_out_data, 4);
        chk("rst_mid_after_count", a_out_count, 4);
        cyc(0, 0, 0, 1);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            automatic int pick = $urandom_range(0, 3);
            automatic logic [IN_W-1:0] d;
            d = (pick == 0) ? 24'hFFFFFF : (pick == 1) ? 24'hFFE001 : IN_W'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
        end
        rst_n = 1'b1;
        cyc(0, 0, 0, 1);
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
